// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer.
//   - state_e      : sequencer FSM state encoding
//   - op_class_e   : execution class an opcode falls into
//   - OP_*         : full 5-bit opcode list
//   - IR_*         : bit positions of the IR fields
//   - op_classify  : maps an opcode to its execution class
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_T6   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3 = 3'd0,
    CLS_IMM  = 3'd1,
    CLS_MD   = 3'd2,
    CLS_UN   = 3'd3,
    CLS_ILL  = 3'd4
  } op_class_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  // ld, ldi and st are deliberately not supported and fall into CLS_ILL.
  function automatic op_class_e op_classify(input logic [4:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:            cls = CLS_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:                 cls = CLS_IMM;
      OP_MUL, OP_DIV:                           cls = CLS_MD;
      OP_NEG, OP_NOT:                           cls = CLS_UN;
      default:                                  cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_reg_decoder.sv
// reg_decoder: 4-to-16 one-hot decoder with enable.
//   i_en     : when low the output is all zeros
//   i_idx    : register index to select
//   o_onehot : one-hot select, bit i_idx set when enabled
module reg_decoder (
  input  logic        i_en,
  input  logic [3:0]  i_idx,
  output logic [15:0] o_onehot
);

  // One-hot decode; index 0 yields bit 0 like any other index.
  always_comb begin
    o_onehot = 16'h0000;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end else begin
      o_onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute control FSM for a simple bus datapath.
//   clk, clr (async active-low), run, mem_ready, ir[31:0]  : inputs
//   pc/mar/mdr/ir/y/z/lo/hi strobes, c_out                 : datapath strobes
//   op_code[4:0]                                           : ALU operation
//   reg_enable[15:0], reg_out[15:0]                        : one-hot register load / drive
//   busy, instr_done, illegal_op                           : status
// Outputs are decoded combinationally from state, ir and (in T1) mem_ready,
// so clr forces them all to zero in the same instant it forces IDLE.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        pc_increment,
  output logic        pc_enable,
  output logic        mar_enable,
  output logic        read,
  output logic        mdr_enable,
  output logic        mdr_out,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        z_enable,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        lo_enable,
  output logic        hi_enable,
  output logic        c_out,
  output logic [4:0]  op_code,
  output logic [15:0] reg_enable,
  output logic [15:0] reg_out,
  output logic        busy,
  output logic        instr_done,
  output logic        illegal_op
);

  state_e    r_state;
  state_e    w_next;
  op_class_e w_cls;
  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_ren_en;
  logic [3:0] w_ren_idx;
  logic       w_rout_en;
  logic [3:0] w_rout_idx;
  state_e     w_done_next;

  assign w_op  = ir[IR_OP_MSB:IR_OP_LSB];
  assign w_ra  = ir[IR_RA_MSB:IR_RA_LSB];
  assign w_rb  = ir[IR_RB_MSB:IR_RB_LSB];
  assign w_rc  = ir[IR_RC_MSB:IR_RC_LSB];
  assign w_cls = op_classify(w_op);

  // run is only sampled at the end of an instruction, never mid-sequence.
  assign w_done_next = run ? ST_T0 : ST_IDLE;

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = run ? ST_T0 : ST_IDLE;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = mem_ready ? ST_T2 : ST_T1;
      ST_T2:   w_next = ST_T3;
      ST_T3:   w_next = (w_cls == CLS_ILL) ? w_done_next : ST_T4;
      ST_T4:   w_next = (w_cls == CLS_UN) ? w_done_next : ST_T5;
      ST_T5:   w_next = (w_cls == CLS_MD) ? ST_T6 : w_done_next;
      ST_T6:   w_next = w_done_next;
      default: w_next = ST_IDLE;
    endcase
  end

  // Strobe decode; register selects go through the two decoders below.
  always_comb begin
    pc_out       = 1'b0;
    pc_increment = 1'b0;
    pc_enable    = 1'b0;
    mar_enable   = 1'b0;
    read         = 1'b0;
    mdr_enable   = 1'b0;
    mdr_out      = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    z_enable     = 1'b0;
    zlo_out      = 1'b0;
    zhi_out      = 1'b0;
    lo_enable    = 1'b0;
    hi_enable    = 1'b0;
    c_out        = 1'b0;
    op_code      = 5'b00000;
    busy         = 1'b1;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    w_ren_en     = 1'b0;
    w_ren_idx    = 4'd0;
    w_rout_en    = 1'b0;
    w_rout_idx   = 4'd0;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_T0: begin
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
        z_enable     = 1'b1;
      end
      ST_T1: begin
        read = 1'b1;
        // The incremented PC is taken from Z only in the cycle data arrives,
        // so it loads exactly once however long the wait lasts.
        if (mem_ready) begin
          mdr_enable = 1'b1;
          zlo_out    = 1'b1;
          pc_enable  = 1'b1;
        end else begin
          mdr_enable = 1'b0;
        end
      end
      ST_T2: begin
        mdr_out   = 1'b1;
        ir_enable = 1'b1;
      end
      ST_T3: begin
        case (w_cls)
          CLS_ALU3, CLS_IMM: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_rb;
            y_enable   = 1'b1;
          end
          CLS_MD: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_ra;
            y_enable   = 1'b1;
          end
          CLS_UN: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_rb;
            op_code    = w_op;
            z_enable   = 1'b1;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      ST_T4: begin
        case (w_cls)
          CLS_ALU3: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_rc;
            op_code    = w_op;
            z_enable   = 1'b1;
          end
          CLS_IMM: begin
            c_out    = 1'b1;
            op_code  = w_op;
            z_enable = 1'b1;
          end
          CLS_MD: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_rb;
            op_code    = w_op;
            z_enable   = 1'b1;
          end
          CLS_UN: begin
            zlo_out    = 1'b1;
            w_ren_en   = 1'b1;
            w_ren_idx  = w_ra;
            instr_done = 1'b1;
          end
          default: busy = 1'b1;
        endcase
      end
      ST_T5: begin
        case (w_cls)
          CLS_ALU3, CLS_IMM: begin
            zlo_out    = 1'b1;
            w_ren_en   = 1'b1;
            w_ren_idx  = w_ra;
            instr_done = 1'b1;
          end
          CLS_MD: begin
            zlo_out   = 1'b1;
            lo_enable = 1'b1;
          end
          default: busy = 1'b1;
        endcase
      end
      ST_T6: begin
        if (w_cls == CLS_MD) begin
          zhi_out    = 1'b1;
          hi_enable  = 1'b1;
          instr_done = 1'b1;
        end else begin
          zhi_out = 1'b0;
        end
      end
      default: busy = 1'b0;
    endcase
  end

  reg_decoder u_dec_enable (
    .i_en     (w_ren_en),
    .i_idx    (w_ren_idx),
    .o_onehot (reg_enable)
  );

  reg_decoder u_dec_out (
    .i_en     (w_rout_en),
    .i_idx    (w_rout_idx),
    .o_onehot (reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer: the driver pushes the
// hand-computed expected outputs for every cycle, a monitor pops and compares.
module tb_control_sequencer;

  typedef struct packed {
    logic [14:0] strb;
    logic [4:0]  op;
    logic [15:0] ren;
    logic [15:0] rout;
    logic        busy;
    logic        done;
    logic        ill;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  // Strobe bit masks in the bench's own packing order.
  localparam logic [14:0] M_PC_OUT  = 15'h0001;
  localparam logic [14:0] M_PC_INC  = 15'h0002;
  localparam logic [14:0] M_PC_EN   = 15'h0004;
  localparam logic [14:0] M_MAR_EN  = 15'h0008;
  localparam logic [14:0] M_RD      = 15'h0010;
  localparam logic [14:0] M_MDR_EN  = 15'h0020;
  localparam logic [14:0] M_MDR_OUT = 15'h0040;
  localparam logic [14:0] M_IR_EN   = 15'h0080;
  localparam logic [14:0] M_Y_EN    = 15'h0100;
  localparam logic [14:0] M_Z_EN    = 15'h0200;
  localparam logic [14:0] M_ZLO     = 15'h0400;
  localparam logic [14:0] M_ZHI     = 15'h0800;
  localparam logic [14:0] M_LO_EN   = 15'h1000;
  localparam logic [14:0] M_HI_EN   = 15'h2000;
  localparam logic [14:0] M_C_OUT   = 15'h4000;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        run = 1'b1;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = 32'h0;
  logic [31:0] cur_ir = 32'h0;

  logic pc_out, pc_increment, pc_enable, mar_enable, read, mdr_enable, mdr_out;
  logic ir_enable, y_enable, z_enable, zlo_out, zhi_out, lo_enable, hi_enable, c_out;
  logic [4:0]  op_code;
  logic [15:0] reg_enable, reg_out;
  logic busy, instr_done, illegal_op;

  obs_t w_obs;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .pc_increment(pc_increment), .pc_enable(pc_enable),
    .mar_enable(mar_enable), .read(read), .mdr_enable(mdr_enable),
    .mdr_out(mdr_out), .ir_enable(ir_enable), .y_enable(y_enable),
    .z_enable(z_enable), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .lo_enable(lo_enable), .hi_enable(hi_enable), .c_out(c_out),
    .op_code(op_code), .reg_enable(reg_enable), .reg_out(reg_out),
    .busy(busy), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  assign w_obs = {c_out, hi_enable, lo_enable, zhi_out, zlo_out, z_enable, y_enable,
                  ir_enable, mdr_out, mdr_enable, read, mar_enable, pc_enable,
                  pc_increment, pc_out, op_code, reg_enable, reg_out,
                  busy, instr_done, illegal_op};

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [14:0] s, input logic [4:0] op,
                              input logic [15:0] ren, input logic [15:0] rout,
                              input logic b, input logic d, input logic il);
    obs_t o;
    o.strb = s; o.op = op; o.ren = ren; o.rout = rout;
    o.busy = b; o.done = d; o.ill = il;
    return o;
  endfunction

  localparam obs_t ZERO = '0;

  // Monitor: compare mid-cycle against the oldest pending expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total = total + 1;
      if (w_obs !== e.v) begin
        bad = bad + 1;
        $display("FAIL %s: got strb=%h op=%b ren=%h rout=%h busy=%b done=%b ill=%b want strb=%h op=%b ren=%h rout=%h busy=%b done=%b ill=%b",
                 e.tag, w_obs.strb, w_obs.op, w_obs.ren, w_obs.rout, w_obs.busy, w_obs.done, w_obs.ill,
                 e.v.strb, e.v.op, e.v.ren, e.v.rout, e.v.busy, e.v.done, e.v.ill);
      end
    end
  end

  task automatic cyc(input logic r, input logic mr, input logic c, input obs_t e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    run = r; mem_ready = mr; clr = c; ir = cur_ir;
    x.v = e; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic fetch(input logic [31:0] instr, input int nwait, input string nm);
    cur_ir = instr;
    cyc(1'b1, 1'b0, 1'b1, mk(M_PC_OUT | M_MAR_EN | M_PC_INC | M_Z_EN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0), {nm, "_t0"});
    for (int i = 0; i < nwait; i++)
      cyc(1'b1, 1'b0, 1'b1, mk(M_RD, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0), {nm, "_t1wait"});
    cyc(1'b1, 1'b1, 1'b1, mk(M_RD | M_MDR_EN | M_ZLO | M_PC_EN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0), {nm, "_t1"});
    cyc(1'b1, 1'b0, 1'b1, mk(M_MDR_OUT | M_IR_EN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0), {nm, "_t2"});
  endtask

  initial begin
    // Reset held, then released; IDLE until run is seen at an edge.
    cyc(1'b1, 1'b0, 1'b0, ZERO, "reset0");
    cyc(1'b1, 1'b0, 1'b0, ZERO, "reset1");
    cyc(1'b0, 1'b0, 1'b1, ZERO, "idle_norun");
    cyc(1'b1, 1'b0, 1'b1, ZERO, "idle_run");

    // and R1,R2,R3 (0x50918000)
    fetch(32'h5091_8000, 0, "and");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Y_EN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0), "and_t3");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Z_EN, 5'b01010, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0), "and_t4");
    cyc(1'b1, 1'b0, 1'b1, mk(M_ZLO, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b1, 1'b0), "and_t5");

    // 0x28918000: opcode field 00101 (shr), R1,R2,R3
    fetch(32'h2891_8000, 0, "shr");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Y_EN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0), "shr_t3");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Z_EN, 5'b00101, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0), "shr_t4");
    cyc(1'b1, 1'b0, 1'b1, mk(M_ZLO, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b1, 1'b0), "shr_t5");

    // mul Ra=4, Rb=5 (0x7A280000): T0..T6 = 7 cycles
    fetch(32'h7A28_0000, 0, "mul");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Y_EN, 5'd0, 16'h0, 16'h0010, 1'b1, 1'b0, 1'b0), "mul_t3");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Z_EN, 5'b01111, 16'h0, 16'h0020, 1'b1, 1'b0, 1'b0), "mul_t4");
    cyc(1'b1, 1'b0, 1'b1, mk(M_ZLO | M_LO_EN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0), "mul_t5");
    cyc(1'b1, 1'b0, 1'b1, mk(M_ZHI | M_HI_EN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0), "mul_t6");

    // addi R0,R0 (0x60000000) with 3 wait cycles in T1; index 0 is one-hot bit 0
    fetch(32'h6000_0000, 3, "addi");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Y_EN, 5'd0, 16'h0, 16'h0001, 1'b1, 1'b0, 1'b0), "addi_t3");
    cyc(1'b1, 1'b0, 1'b1, mk(M_C_OUT | M_Z_EN, 5'b01100, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0), "addi_t4");
    cyc(1'b1, 1'b0, 1'b1, mk(M_ZLO, 5'd0, 16'h0001, 16'h0, 1'b1, 1'b1, 1'b0), "addi_t5");

    // ld (opcode 00000) is illegal: illegal_op only, then straight to T0
    fetch(32'h0000_0000, 0, "ld");
    cyc(1'b1, 1'b0, 1'b1, mk(15'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1), "ld_t3");

    // neg R6,R7 (0x8B380000) with run dropped in T3: completes, then IDLE
    fetch(32'h8B38_0000, 0, "neg");
    cyc(1'b0, 1'b0, 1'b1, mk(M_Z_EN, 5'b10001, 16'h0, 16'h0080, 1'b1, 1'b0, 1'b0), "neg_t3");
    cyc(1'b0, 1'b0, 1'b1, mk(M_ZLO, 5'd0, 16'h0040, 16'h0, 1'b1, 1'b1, 1'b0), "neg_t4");
    cyc(1'b0, 1'b0, 1'b1, ZERO, "neg_idle");
    cyc(1'b1, 1'b0, 1'b1, ZERO, "neg_idle_run");

    // clr pulsed during T4 of and: outputs drop in the same cycle
    fetch(32'h5091_8000, 0, "clr");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Y_EN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0), "clr_t3");
    cyc(1'b1, 1'b0, 1'b0, ZERO, "clr_in_t4");
    cyc(1'b1, 1'b0, 1'b1, ZERO, "clr_release");
    fetch(32'h5091_8000, 0, "restart");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Y_EN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0), "restart_t3");
    cyc(1'b1, 1'b0, 1'b1, mk(M_Z_EN, 5'b01010, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0), "restart_t4");
    cyc(1'b0, 1'b0, 1'b1, mk(M_ZLO, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b1, 1'b0), "restart_t5");
    cyc(1'b0, 1'b0, 1'b1, ZERO, "final_idle");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
